// File: rtl/sdram_ctrl_pkg.sv
// rtl/sdram_ctrl_pkg.sv - shared types and helpers for the SDRAM controller port arbiter
package sdram_ctrl_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_TIERS = 4;

    // Binary index of a one-hot vector of up to 16 ports (0 when empty).
    function automatic int onehot2bin(input logic [15:0] oh);
        int b;
        b = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                b = b | i;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// rtl/sdram_rr_picker.sv - first set request at or after rr_ptr, with wrap-around
module sdram_rr_picker #(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] rr_ptr,
    output logic [PORTS-1:0]         pick,
    output logic                     found
);

    localparam int IW = $clog2(PORTS);

    // Walk the ports starting at rr_ptr and keep only the first requester.
    always_comb begin
        logic [IW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < PORTS; i++) begin
            idx = IW'((int'(rr_ptr) + i) % PORTS);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - N-port tiered arbiter feeding the SDRAM scheduler (row-hit tier: SDRAM_ARB_ROWHIT_EN)
module sdram_port_arbiter
    import sdram_ctrl_pkg::*;
#(
    parameter int PORTS     = 4,
    parameter int CTRL_PORT = 0,
    parameter int BA_SIZE   = 2,
    parameter int MAX_RSIZE = 13,
    parameter int AGE_LIMIT = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   ena_i,
    input  logic [PORTS-1:0]                       rdreq_i,
    input  logic [PORTS-1:0]                       wrreq_i,
    input  logic [PORTS-1:0]                       wbr_i,
    input  logic [PORTS-1:0][BA_SIZE-1:0]          ba_i,
    input  logic [PORTS-1:0][MAX_RSIZE-1:0]        row_i,
    input  logic [(2**BA_SIZE)-1:0]                bank_open_i,
    input  logic [(2**BA_SIZE)-1:0][MAX_RSIZE-1:0] open_row_i,
    input  logic                                   done_i,
    output logic                                   gnt_vld_o,
    output logic [PORTS-1:0]                       gnt_o,
    output logic [$clog2(PORTS)-1:0]               gnt_id_o,
    output logic                                   gnt_wr_o
);

    localparam int IDW = $clog2(PORTS);
    localparam int AW  = $clog2(AGE_LIMIT + 1);
    localparam logic [PORTS-1:0] CTRL_MASK = PORTS'(1) << CTRL_PORT;

    arb_state_t                            state;
    logic [IDW-1:0]                        rr_ptr;
    logic [PORTS-1:0][AW-1:0]              age;
    logic [PORTS-1:0]                      req;
    logic [PORTS-1:0]                      elig;
    logic [PORTS-1:0]                      hit;
    logic [ARB_TIERS-1:0][PORTS-1:0]       tier_req;
    logic [ARB_TIERS-1:0][PORTS-1:0]       tier_pick;
    logic [ARB_TIERS-1:0]                  tier_found;
    logic [PORTS-1:0]                      win_oh;
    logic                                  win_any;
    logic [IDW-1:0]                        win_id;
    logic [IDW-1:0]                        rr_next;
    logic [15:0]                           win_oh16;
    logic                                  grant_now;

    assign req  = rdreq_i | wrreq_i;
    assign elig = ena_i ? req : (req & CTRL_MASK);

`ifdef SDRAM_ARB_ROWHIT_EN
    // A request hits when its bank is open on the same row it wants.
    always_comb begin
        hit = '0;
        for (int p = 0; p < PORTS; p++) begin
            hit[p] = bank_open_i[ba_i[p]] && (open_row_i[ba_i[p]] == row_i[p]);
        end
    end
`else
    logic unused_rowhit;
    assign hit           = '0;
    assign unused_rowhit = ^{ba_i, row_i, bank_open_i, open_row_i};
`endif

    // Build the candidate set of each tier, highest priority first.
    always_comb begin
        tier_req = '0;
        for (int p = 0; p < PORTS; p++) begin
            tier_req[0][p] = elig[p] && (age[p] == AW'(AGE_LIMIT));
        end
        tier_req[1] = elig & wbr_i & wrreq_i;
        tier_req[2] = elig & hit;
        tier_req[3] = elig;
    end

    for (genvar t = 0; t < ARB_TIERS; t++) begin : g_tier
        sdram_rr_picker #(.PORTS(PORTS)) u_pick (
            .req    (tier_req[t]),
            .rr_ptr (rr_ptr),
            .pick   (tier_pick[t]),
            .found  (tier_found[t])
        );
    end

    // The first tier with any candidate supplies the winner.
    always_comb begin
        win_oh  = '0;
        win_any = 1'b0;
        for (int t = 0; t < ARB_TIERS; t++) begin
            if (!win_any && tier_found[t]) begin
                win_oh  = tier_pick[t];
                win_any = 1'b1;
            end
        end
        win_oh16              = '0;
        win_oh16[PORTS-1:0]   = win_oh;
    end

    assign win_id    = IDW'(onehot2bin(win_oh16));
    assign rr_next   = (win_id == IDW'(PORTS - 1)) ? '0 : win_id + IDW'(1);
    assign grant_now = (state == ARB_IDLE) && win_any;

    // Grant FSM: register the winner in IDLE, hold it until the scheduler reports done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            gnt_vld_o <= 1'b0;
            gnt_o     <= '0;
            gnt_id_o  <= '0;
            gnt_wr_o  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win_any) begin
                        state     <= ARB_GRANT;
                        rr_ptr    <= rr_next;
                        gnt_vld_o <= 1'b1;
                        gnt_o     <= win_oh;
                        gnt_id_o  <= win_id;
                        gnt_wr_o  <= |(win_oh & wrreq_i);
                    end
                end
                ARB_GRANT: begin
                    if (done_i) begin
                        state     <= ARB_IDLE;
                        gnt_vld_o <= 1'b0;
                        gnt_o     <= '0;
                        gnt_id_o  <= '0;
                        gnt_wr_o  <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Per-port waiting time: grows while a request is pending and not being served.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (!req[p]) begin
                    age[p] <= '0;
                end else if (grant_now && win_oh[p]) begin
                    age[p] <= '0;
                end else if (gnt_vld_o && gnt_o[p]) begin
                    age[p] <= age[p];
                end else if (age[p] != AW'(AGE_LIMIT)) begin
                    age[p] <= age[p] + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter with a behavioural model
module tb_sdram_port_arbiter;

    localparam int LIM = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             done = 1'b0;
    logic [3:0]       rdreq = '0;
    logic [3:0]       wrreq = '0;
    logic [3:0]       wbr = '0;
    logic [3:0][1:0]  ba = '0;
    logic [3:0][12:0] row = '0;
    logic [3:0]       bank_open = '0;
    logic [3:0][12:0] open_row = '0;
    logic             gnt_vld;
    logic [3:0]       gnt;
    logic [1:0]       gnt_id;
    logic             gnt_wr;

    int n_cmp = 0;
    int n_bad = 0;

    int m_vld, m_id, m_wr, m_ptr;
    int m_age[4];
    int g_cnt;
    int gq[$];
    int gw[$];

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .PORTS(4), .CTRL_PORT(0), .BA_SIZE(2), .MAX_RSIZE(13), .AGE_LIMIT(LIM)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ena_i(ena),
        .rdreq_i(rdreq), .wrreq_i(wrreq), .wbr_i(wbr),
        .ba_i(ba), .row_i(row), .bank_open_i(bank_open), .open_row_i(open_row),
        .done_i(done),
        .gnt_vld_o(gnt_vld), .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_wr_o(gnt_wr)
    );

    function automatic logic [7:0] exp_vec();
        logic [7:0] v;
        v = '0;
        if (m_vld != 0) begin
            v[7]   = 1'b1;
            v[6:3] = 4'(1 << m_id);
            v[2:1] = 2'(m_id);
            v[0]   = 1'(m_wr);
        end
        return v;
    endfunction

    function automatic bit row_hit(input int p);
`ifdef SDRAM_ARB_ROWHIT_EN
        return bank_open[ba[p]] && (open_row[ba[p]] == row[p]);
`else
        return (p < 0);
`endif
    endfunction

    // Tiers in priority order; inside a tier, ports are visited from the round-robin pointer.
    function automatic int pick(input logic [3:0] el);
        int p;
        bit c;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_ptr + k) % 4;
                case (t)
                    0:       c = el[p] && (m_age[p] == LIM);
                    1:       c = el[p] && wbr[p] && wrreq[p];
                    2:       c = el[p] && row_hit(p);
                    default: c = el[p];
                endcase
                if (c) return p;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_wr = 0; m_ptr = 0;
        for (int p = 0; p < 4; p++) m_age[p] = 0;
    endtask

    // Advance model and DUT by one clock; leaves time at posedge + 1.
    task automatic cyc();
        logic [3:0] el;
        int win;
        int nage[4];
        for (int p = 0; p < 4; p++) el[p] = (rdreq[p] | wrreq[p]) && (ena || p == 0);
        win = (m_vld != 0) ? -1 : pick(el);
        for (int p = 0; p < 4; p++) begin
            if (!(rdreq[p] | wrreq[p]))          nage[p] = 0;
            else if (win == p)                   nage[p] = 0;
            else if (m_vld != 0 && m_id == p)    nage[p] = m_age[p];
            else                                 nage[p] = (m_age[p] < LIM) ? m_age[p] + 1 : LIM;
        end
        if (m_vld != 0) begin
            if (done) begin m_vld = 0; m_id = 0; m_wr = 0; end
        end else if (win >= 0) begin
            m_vld = 1; m_id = win; m_wr = int'(wrreq[win]); m_ptr = (win + 1) % 4;
        end
        for (int p = 0; p < 4; p++) m_age[p] = nage[p];
        @(posedge clk);
        #1;
    endtask

    // Scheduler stand-in: done two cycles after each grant; records grants as seen on the DUT.
    task automatic step_auto();
        done = (g_cnt == 2);
        cyc();
        if (m_vld != 0) g_cnt++; else g_cnt = 0;
        if (m_vld != 0 && g_cnt == 1) begin
            gq.push_back(int'(gnt_id));
            gw.push_back(int'(gnt_wr));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; done = 1'b0;
        rdreq = '0; wrreq = '0; wbr = '0; ba = '0; row = '0; bank_open = '0; open_row = '0;
        model_reset();
        g_cnt = 0; gq.delete(); gw.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({gnt_vld, gnt, gnt_id, gnt_wr} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=00", {gnt_vld, gnt, gnt_id, gnt_wr});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ena = 1'b1; rdreq = 4'b1110;
        for (int c = 0; c < 40 && gq.size() < 4; c++) begin
            step_auto();
            n_cmp++;
            if ({gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
                n_bad++;
                $display("FAIL rr_model t=%0t got=%h exp=%h", $time, {gnt_vld, gnt, gnt_id, gnt_wr}, exp_vec());
            end
            if (c == 0) begin
                n_cmp++;
                if (gnt_vld !== 1'b1 || gnt_id !== 2'd1) begin
                    n_bad++;
                    $display("FAIL rr_latency got vld=%b id=%0d exp vld=1 id=1", gnt_vld, gnt_id);
                end
            end
        end
        n_cmp++;
        if (gq.size() < 4 || gq[0] != 1 || gq[1] != 2 || gq[2] != 3 || gq[3] != 1) begin
            n_bad++;
            $display("FAIL rr_sequence got=%p exp=1,2,3,1", gq);
        end
    endtask

    task automatic test_ctrl_mode();
        do_reset();
        ena = 1'b0; wrreq = 4'hF;
        for (int c = 0; c < 40 && gq.size() < 3; c++) begin
            step_auto();
            n_cmp++;
            if ({gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
                n_bad++;
                $display("FAIL ctrl_model t=%0t got=%h exp=%h", $time, {gnt_vld, gnt, gnt_id, gnt_wr}, exp_vec());
            end
        end
        n_cmp++;
        if (gq.size() != 3 || gq[0] != 0 || gq[1] != 0 || gq[2] != 0 || gw[0] != 1) begin
            n_bad++;
            $display("FAIL ctrl_only_port0 got=%p exp=0,0,0 (write)", gq);
        end
        ena = 1'b1;
        for (int c = 0; c < 20 && gq.size() < 4; c++) begin
            step_auto();
            n_cmp++;
            if ({gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
                n_bad++;
                $display("FAIL ctrl_ena_model t=%0t got=%h exp=%h", $time, {gnt_vld, gnt, gnt_id, gnt_wr}, exp_vec());
            end
        end
        n_cmp++;
        if (gq.size() != 4 || gq[3] != 1) begin
            n_bad++;
            $display("FAIL ctrl_ena_next got=%p exp last=1", gq);
        end
    endtask

    task automatic test_wbr_priority();
        do_reset();
        ena = 1'b1; rdreq = 4'b0001;
        for (int c = 0; c < 10 && gq.size() < 1; c++) step_auto();
        rdreq = 4'b0010; wrreq = 4'b0100; wbr = 4'b0100;
        for (int c = 0; c < 20 && gq.size() < 2; c++) begin
            step_auto();
            n_cmp++;
            if ({gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
                n_bad++;
                $display("FAIL wbr_model t=%0t got=%h exp=%h", $time, {gnt_vld, gnt, gnt_id, gnt_wr}, exp_vec());
            end
        end
        n_cmp++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 2 || gw[1] != 1) begin
            n_bad++;
            $display("FAIL wbr_first got=%p exp=0,2 (write)", gq);
        end
    endtask

    task automatic test_aging();
        do_reset();
        ena = 1'b1; wrreq = 4'b0011; wbr = 4'b0011; rdreq = 4'b1000;
        for (int c = 0; c < 40 && gq.size() < 3; c++) begin
            step_auto();
            n_cmp++;
            if ({gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
                n_bad++;
                $display("FAIL age_model t=%0t got=%h exp=%h", $time, {gnt_vld, gnt, gnt_id, gnt_wr}, exp_vec());
            end
        end
        n_cmp++;
        if (gq.size() != 3 || gq[0] != 0 || gq[1] != 1 || gq[2] != 3 || gw[2] != 0) begin
            n_bad++;
            $display("FAIL age_starved got=%p exp=0,1,3 (read last)", gq);
        end
    endtask

    task automatic test_rowhit();
        int exp_id;
`ifdef SDRAM_ARB_ROWHIT_EN
        exp_id = 3;
`else
        exp_id = 0;
`endif
        do_reset();
        ena = 1'b1; bank_open = 4'b0010; open_row[1] = 13'h123;
        ba[3] = 2'd1; row[3] = 13'h123; ba[0] = 2'd0; row[0] = 13'h055;
        rdreq = 4'b1001;
        cyc();
        n_cmp++;
        if (gnt_vld !== 1'b1 || int'(gnt_id) != exp_id || {gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
            n_bad++;
            $display("FAIL rowhit_first got vld=%b id=%0d exp vld=1 id=%0d", gnt_vld, gnt_id, exp_id);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        ena = 1'b1; rdreq = 4'b0100;
        for (int c = 0; c < 10 && gq.size() < 1; c++) step_auto();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt_vld !== 1'b0 || gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL async_reset got vld=%b gnt=%b exp vld=0 gnt=0000", gnt_vld, gnt);
        end
        model_reset();
        rdreq = '0; g_cnt = 0; gq.delete(); gw.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdreq = 4'b1010; wrreq = 4'b0010;
        cyc();
        n_cmp++;
        if ({gnt_vld, gnt, gnt_id, gnt_wr} !== 8'b1_0010_01_1 || {gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
            n_bad++;
            $display("FAIL post_reset_rdwr got=%b exp=10010011", {gnt_vld, gnt, gnt_id, gnt_wr});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rdreq = 4'($urandom) & 4'($urandom);
            wrreq = 4'($urandom) & 4'($urandom);
            wbr   = 4'($urandom);
            ena   = ($urandom_range(0, 9) != 0);
            done  = ($urandom_range(0, 2) == 0);
            bank_open = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                ba[p]       = 2'($urandom);
                row[p]      = 13'h120 + 13'($urandom_range(0, 1));
                open_row[p] = 13'h120 + 13'($urandom_range(0, 1));
            end
            cyc();
            n_cmp++;
            if ({gnt_vld, gnt, gnt_id, gnt_wr} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", c, {gnt_vld, gnt, gnt_id, gnt_wr}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ctrl_mode();
        test_wbr_priority();
        test_aging();
        test_rowhit();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
